// File: rtl/masked_share_source_if.sv
// Bundle between masked_share_source and its environment: seed load, operand
// input handshake, share-set output handshake, plus status/debug.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the valid side holds its payload stable until that edge, and ready
// may depend combinationally on valid, never the reverse.
interface masked_share_source_if #(
   parameter int LFSR_W = 32
);
   logic              seed_valid;
   logic [LFSR_W-1:0] seed;
   logic              in_valid;
   logic              in_ready;
   logic              i_a;
   logic              i_b;
   logic              out_valid;
   logic              out_ready;
   logic              o_a0;
   logic              o_a1;
   logic              o_b0;
   logic              o_b1;
   logic              o_rN;
   logic              busy;
   logic              dbg_state;

   // master: the environment driving operands/seed and consuming shares
   modport master (
      output seed_valid, seed, in_valid, i_a, i_b, out_ready,
      input  in_ready, out_valid, o_a0, o_a1, o_b0, o_b1, o_rN, busy, dbg_state
   );

   // slave: the share source itself
   modport slave (
      input  seed_valid, seed, in_valid, i_a, i_b, out_ready,
      output in_ready, out_valid, o_a0, o_a1, o_b0, o_b1, o_rN, busy, dbg_state
   );
endinterface

// File: rtl/masked_share_source.sv
// Splits operands a/b into two Boolean shares each and supplies a fresh random
// bit, drawn from a reseedable Galois LFSR that free-runs for WARMUP cycles.
module masked_share_source #(
   parameter int                LFSR_W       = 32,
   parameter logic [LFSR_W-1:0] POLY         = 32'h80200003,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1ACE1,
   parameter int                WARMUP       = 16
) (
   input logic                  clk,
   input logic                  rst,
   masked_share_source_if.slave bus
);

   typedef enum logic [0:0] {
      ST_WARM  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int                CNT_W      = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [CNT_W-1:0]  WARM_LAST  = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
   localparam state_t            INIT_STATE = (WARMUP == 0) ? ST_READY : ST_WARM;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic              out_valid_q;
   logic              o_a0_q, o_a1_q, o_b0_q, o_b1_q, o_rn_q;
   logic              in_ready_c;
   logic              accept;

   function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] x);
      return (x >> 1) ^ (x[0] ? POLY : '0);
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lfsr_d     = lfsr_q;
      accept     = 1'b0;
      // a seed load blocks the operand port for its cycle
      in_ready_c = (state_q == ST_READY) && (!out_valid_q || bus.out_ready) && !bus.seed_valid;
      if (bus.seed_valid) begin
         state_d = INIT_STATE;
         cnt_d   = '0;
         lfsr_d  = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
      end else if (state_q == ST_WARM) begin
         lfsr_d = step(lfsr_q);
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == WARM_LAST) begin
            state_d = ST_READY;
         end
      end else if (bus.in_valid && in_ready_c) begin
         accept = 1'b1;
         // three bits are consumed per transaction, so advance three steps
         lfsr_d = step(step(step(lfsr_q)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT_STATE;
         cnt_q   <= '0;
         lfsr_q  <= DEFAULT_SEED;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
      end
   end

   // share register: masks come from the pre-advance LFSR value
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         o_a0_q      <= 1'b0;
         o_a1_q      <= 1'b0;
         o_b0_q      <= 1'b0;
         o_b1_q      <= 1'b0;
         o_rn_q      <= 1'b0;
      end else if (bus.seed_valid) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         o_a0_q      <= bus.i_a ^ lfsr_q[0];
         o_a1_q      <= lfsr_q[0];
         o_b0_q      <= bus.i_b ^ lfsr_q[1];
         o_b1_q      <= lfsr_q[1];
         o_rn_q      <= lfsr_q[2];
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.o_a0      = o_a0_q;
   assign bus.o_a1      = o_a1_q;
   assign bus.o_b0      = o_b0_q;
   assign bus.o_b1      = o_b1_q;
   assign bus.o_rN      = o_rn_q;
   assign bus.busy      = (state_q == ST_WARM);
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_masked_share_source.sv
// Bench for masked_share_source: a transaction-level model with a share-set
// scoreboard, plus a WARMUP=0 instance checked against hand-computed vectors.
module tb_masked_share_source;

  localparam logic [31:0] POLY         = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1ACE1;
  localparam int          WARMUP       = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  masked_share_source_if #(.LFSR_W(32)) bus ();
  masked_share_source_if #(.LFSR_W(32)) bus0 ();

  masked_share_source #(
    .LFSR_W(32), .POLY(POLY), .DEFAULT_SEED(DEFAULT_SEED), .WARMUP(WARMUP)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  masked_share_source #(
    .LFSR_W(32), .POLY(POLY), .DEFAULT_SEED(DEFAULT_SEED), .WARMUP(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] x, input int n);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    return v;
  endfunction

  // behavioural model: LFSR value, remaining warm-up cycles, held share set
  logic [31:0] m_lfsr;
  int          m_warm;
  bit          m_valid;
  logic [4:0]  m_set;
  bit          live = 1'b0;
  logic [4:0]  exp_q[$];

  // scoreboard/compare: check DUT against model, then advance model by one edge
  initial forever begin
    logic [4:0] got, exp;
    bit         pred_ready, acc;
    @(negedge clk);
    if (live) begin
      got = {bus.o_a0, bus.o_a1, bus.o_b0, bus.o_b1, bus.o_rN};
      pred_ready = (m_warm == 0) && (!m_valid || bus.out_ready) && !bus.seed_valid;
      check("in_ready", bus.in_ready == pred_ready, 64'(bus.in_ready), 64'(pred_ready));
      check("busy", bus.busy == (m_warm > 0), 64'(bus.busy), 64'(m_warm > 0));
      check("out_valid", bus.out_valid == m_valid, 64'(bus.out_valid), 64'(m_valid));
      check("shares", got == m_set, 64'(got), 64'(m_set));
      check("lfsr", u_dut.lfsr_q == m_lfsr, 64'(u_dut.lfsr_q), 64'(m_lfsr));
      check("lfsr_nonzero", u_dut.lfsr_q != 32'h0, 64'(u_dut.lfsr_q), 64'(m_lfsr));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 1'b0, 64'(got), 64'h0);
        end else begin
          exp = exp_q.pop_front();
          check("sb_transfer", got == exp, 64'(got), 64'(exp));
        end
      end
    end
    if (rst) begin
      m_lfsr = DEFAULT_SEED; m_warm = WARMUP; m_valid = 1'b0; m_set = '0;
      exp_q.delete();
      live = 1'b1;
    end else if (bus.seed_valid) begin
      m_lfsr = (bus.seed == 32'h0) ? DEFAULT_SEED : bus.seed;
      m_warm = WARMUP;
      if (m_valid && !bus.out_ready) void'(exp_q.pop_back());
      m_valid = 1'b0;
    end else if (m_warm > 0) begin
      m_lfsr = galois(m_lfsr, 1);
      m_warm--;
    end else begin
      acc = bus.in_valid && (!m_valid || bus.out_ready);
      if (bus.out_ready) m_valid = 1'b0;
      if (acc) begin
        m_set = {bus.i_a ^ m_lfsr[0], m_lfsr[0], bus.i_b ^ m_lfsr[1], m_lfsr[1], m_lfsr[2]};
        exp_q.push_back(m_set);
        m_valid = 1'b1;
        m_lfsr  = galois(m_lfsr, 3);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit a, input bit b, input bit ordy);
    bus.in_valid  = iv;
    bus.i_a       = a;
    bus.i_b       = b;
    bus.out_ready = ordy;
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    failures++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ntx, cyc, ones_a, ones_b, ones_r;
    rst = 1'b1;
    bus.seed_valid = 1'b0; bus.seed = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    bus0.seed_valid = 1'b0; bus0.seed = '0;
    bus0.in_valid = 1'b0; bus0.i_a = 1'b0; bus0.i_b = 1'b0; bus0.out_ready = 1'b1;
    tick();
    tick();

    // reset state of both instances
    @(negedge clk);
    check("rst_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'h0);
    check("rst_shares", {bus.o_a0, bus.o_a1, bus.o_b0, bus.o_b1, bus.o_rN} == 5'b0,
          64'({bus.o_a0, bus.o_a1, bus.o_b0, bus.o_b1, bus.o_rN}), 64'h0);
    check("rst_busy", bus.busy == 1'b1, 64'(bus.busy), 64'h1);
    check("rst_in_ready", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'h0);
    check("rst_w0_in_ready", bus0.in_ready == 1'b1, 64'(bus0.in_ready), 64'h1);
    check("rst_w0_busy", bus0.busy == 1'b0, 64'(bus0.busy), 64'h0);
    check("model_pin", galois(32'h1, 3) == 32'h60180001, 64'(galois(32'h1, 3)), 64'h60180001);

    // warm-up with in_valid held high
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("warmup_len", n == WARMUP, 64'(n), 64'(WARMUP));
    check("warmup_busy_low", bus.busy == 1'b0, 64'(bus.busy), 64'h0);
    check("pre_accept_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'h0);
    @(negedge clk);
    check("first_out_latency", bus.out_valid == 1'b1, 64'(bus.out_valid), 64'h1);

    // WARMUP=0 instance: seed=1 directed vectors
    tick();
    bus0.seed_valid = 1'b1; bus0.seed = 32'h1;
    tick();
    bus0.seed_valid = 1'b0;
    bus0.in_valid = 1'b1; bus0.i_a = 1'b1; bus0.i_b = 1'b1;
    tick();
    bus0.i_a = 1'b0; bus0.i_b = 1'b1;
    @(negedge clk);
    check("w0_set1_valid", bus0.out_valid == 1'b1, 64'(bus0.out_valid), 64'h1);
    check("w0_set1", {bus0.o_a0, bus0.o_a1, bus0.o_b0, bus0.o_b1, bus0.o_rN} == 5'b01100,
          64'({bus0.o_a0, bus0.o_a1, bus0.o_b0, bus0.o_b1, bus0.o_rN}), 64'b01100);
    check("w0_lfsr", u_dut0.lfsr_q == 32'h60180001, 64'(u_dut0.lfsr_q), 64'h60180001);
    tick();
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("w0_set2", {bus0.o_a0, bus0.o_a1, bus0.o_b0, bus0.o_b1, bus0.o_rN} == 5'b11100,
          64'({bus0.o_a0, bus0.o_a1, bus0.o_b0, bus0.o_b1, bus0.o_rN}), 64'b11100);
    tick();
    @(negedge clk);
    check("w0_drain_valid", bus0.out_valid == 1'b0, 64'(bus0.out_valid), 64'h0);
    check("w0_drain_hold", {bus0.o_a0, bus0.o_a1, bus0.o_b0, bus0.o_b1, bus0.o_rN} == 5'b11100,
          64'({bus0.o_a0, bus0.o_a1, bus0.o_b0, bus0.o_b1, bus0.o_rN}), 64'b11100);

    // backpressure: 5 stalled cycles, then back-to-back transfers
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'h0);
      check("stall_valid", bus.out_valid == 1'b1, 64'(bus.out_valid), 64'h1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) n++;
      tick();
    end
    check("back_to_back", n == 6, 64'(n), 64'h6);

    // reseed with zero while a set is pending and an input is offered
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    bus.seed_valid = 1'b1; bus.seed = 32'h0;
    @(negedge clk);
    check("reseed_in_ready", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'h0);
    tick();
    bus.seed_valid = 1'b0;
    @(negedge clk);
    check("reseed_drop", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'h0);
    check("reseed_default", u_dut.lfsr_q == DEFAULT_SEED, 64'(u_dut.lfsr_q), 64'(DEFAULT_SEED));
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("reseed_warmup_len", n == WARMUP, 64'(n), 64'(WARMUP));
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (8) tick();

    // random traffic: invariants via model, plus mask bit balance
    ntx = 0; cyc = 0; ones_a = 0; ones_b = 0; ones_r = 0;
    while (ntx < 10000 && cyc < 40000) begin
      drive($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        ntx++;
        ones_a += int'(bus.o_a1);
        ones_b += int'(bus.o_b1);
        ones_r += int'(bus.o_rN);
      end
      tick();
      cyc++;
    end
    check("random_tx_count", ntx == 10000, 64'(ntx), 64'd10000);
    check("freq_a1", ones_a >= 4800 && ones_a <= 5200, 64'(ones_a), 64'd5000);
    check("freq_b1", ones_b >= 4800 && ones_b <= 5200, 64'(ones_b), 64'd5000);
    check("freq_rN", ones_r >= 4800 && ones_r <= 5200, 64'(ones_r), 64'd5000);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    summary();
    $finish;
  end

endmodule
